// File: rtl/riot_pkg.sv
// Shared RIOT port definitions: idle levels, bit positions of the console
// switches and joystick lines, and a counter-width helper.
package riot_pkg;

    localparam logic [7:0] RIOT_PA_IDLE = 8'hFF;
    localparam logic [7:0] RIOT_PB_IDLE = 8'hFF;

    // Port B console switches
    localparam int PB_RESET  = 0;
    localparam int PB_SELECT = 1;
    localparam int PB_COLOR  = 3;
    localparam int PB_DIFF0  = 6;
    localparam int PB_DIFF1  = 7;

    // Port A joysticks, active low
    localparam int P0_RIGHT = 7;
    localparam int P0_LEFT  = 6;
    localparam int P0_DOWN  = 5;
    localparam int P0_UP    = 4;
    localparam int P1_RIGHT = 3;
    localparam int P1_LEFT  = 2;
    localparam int P1_DOWN  = 1;
    localparam int P1_UP    = 0;

    typedef struct packed {
        logic [7:0] pb;
        logic [7:0] pa;
    } riot_ports_t;

    // Counter width for a modulus of n; never narrower than one bit.
    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/riot_debounce_bit.sv
// One conditioned input bit: synchronizer chain, tick-sampled debounce
// counter, registered clean level and a one-cycle change strobe.
module riot_debounce_bit
    import riot_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_TICKS    = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic tick,
    input  logic bypass,
    input  logic clr,
    input  logic rst_val,
    input  logic raw,
    output logic out,
    output logic chg
);

    localparam int            CW       = ctr_width(DB_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CW-1:0]          cnt_reg;
    logic                   out_reg;
    logic                   chg_reg;
    logic                   s;

    assign s   = sync_reg[SYNC_STAGES-1];
    assign out = out_reg;
    assign chg = chg_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= {SYNC_STAGES{rst_val}};
            cnt_reg  <= '0;
            out_reg  <= rst_val;
            chg_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
            chg_reg  <= 1'b0;
            if (bypass) begin
                out_reg <= s;
                chg_reg <= s ^ out_reg;
                cnt_reg <= '0;
            end else if (clr) begin
                // Leaving bypass: start counting from scratch, keep the level.
                cnt_reg <= '0;
            end else if (tick) begin
                if (s == out_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                    out_reg <= s;
                    cnt_reg <= '0;
                    chg_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/riot_port_conditioner.sv
// Conditions the 16 raw controller/switch pins into clean RIOT PA/PB inputs,
// sharing one debounce sample prescaler across all bits.
module riot_port_conditioner
    import riot_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         TICK_DIV    = 256,
    parameter int         DB_TICKS    = 4,
    parameter logic [7:0] RESET_PA    = RIOT_PA_IDLE,
    parameter logic [7:0] RESET_PB    = RIOT_PB_IDLE
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       BYPASS,
    input  logic [7:0] PA_RAW,
    input  logic [7:0] PB_RAW,
    output logic [7:0] PA,
    output logic [7:0] PB,
    output logic [7:0] PA_CHG,
    output logic [7:0] PB_CHG
);

    localparam int            PW         = ctr_width(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_reg;
    logic          tick;
    logic          bypass_reg;
    logic          bypass_clr;
    riot_ports_t   raw_all;
    riot_ports_t   rst_all;
    riot_ports_t   out_all;
    riot_ports_t   chg_all;

    assign tick       = (presc_reg == PRESC_LAST);
    assign bypass_clr = BYPASS ^ bypass_reg;

    always_ff @(posedge CLK) begin
        if (RES || tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PW'(1);
        end
        bypass_reg <= BYPASS;
    end

    assign raw_all = '{pb: PB_RAW, pa: PA_RAW};
    assign rst_all = '{pb: RESET_PB, pa: RESET_PA};

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_bit
            riot_debounce_bit #(
                .SYNC_STAGES(SYNC_STAGES),
                .DB_TICKS   (DB_TICKS)
            ) u_bit (
                .clk    (CLK),
                .srst   (RES),
                .tick   (tick),
                .bypass (BYPASS),
                .clr    (bypass_clr),
                .rst_val(rst_all[gi]),
                .raw    (raw_all[gi]),
                .out    (out_all[gi]),
                .chg    (chg_all[gi])
            );
        end
    endgenerate

    assign PA     = out_all.pa;
    assign PB     = out_all.pb;
    assign PA_CHG = chg_all.pa;
    assign PB_CHG = chg_all.pb;

endmodule

// File: tb/tb_riot_port_conditioner.sv
// Bench for riot_port_conditioner: cycle reference model, vector table,
// directed corner sequences and randomized pin activity.
module tb_riot_port_conditioner;

    localparam int          SYNC    = 2;
    localparam int          TD      = 4;
    localparam int          DB      = 3;
    localparam int          LOGN    = 16384;
    localparam logic [15:0] RST_ALL = 16'hFFFF;

    logic       CLK = 1'b0;
    logic       RES;
    logic       BYPASS;
    logic [7:0] PA_RAW;
    logic [7:0] PB_RAW;
    logic [7:0] PA;
    logic [7:0] PB;
    logic [7:0] PA_CHG;
    logic [7:0] PB_CHG;

    int n_vec = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    riot_port_conditioner #(
        .SYNC_STAGES(SYNC),
        .TICK_DIV   (TD),
        .DB_TICKS   (DB),
        .RESET_PA   (8'hFF),
        .RESET_PB   (8'hFF)
    ) dut (
        .CLK   (CLK),
        .RES   (RES),
        .BYPASS(BYPASS),
        .PA_RAW(PA_RAW),
        .PB_RAW(PB_RAW),
        .PA    (PA),
        .PB    (PB),
        .PA_CHG(PA_CHG),
        .PB_CHG(PB_CHG)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int v, input int lo, input int hi);
        n_vec++;
        if (v < lo || v > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, v, lo, hi, $time);
        end
    endtask

    // Reference model: the synchronized level is simply the raw pins from
    // SYNC edges ago; a bit flips once DB consecutive tick samples disagree.
    logic [15:0] raw_log [LOGN];
    logic [15:0] out_m;
    logic [15:0] chg_m;
    int          run_m [16];
    int          rel_m;
    int          t_abs;
    logic        byp_prev;

    always @(posedge CLK) begin : model_blk
        logic [15:0] s_v;
        logic [15:0] o_v;
        logic [15:0] c_v;
        logic        tk;
        if (RES) begin
            out_m    <= RST_ALL;
            chg_m    <= '0;
            rel_m    <= 0;
            byp_prev <= BYPASS;
            for (int b = 0; b < 16; b++) run_m[b] <= 0;
        end else begin
            raw_log[t_abs % LOGN] <= {PB_RAW, PA_RAW};
            s_v = (rel_m >= SYNC) ? raw_log[(t_abs - SYNC) % LOGN] : RST_ALL;
            tk  = (rel_m % TD) == TD - 1;
            o_v = out_m;
            c_v = '0;
            if (BYPASS) begin
                c_v = s_v ^ out_m;
                o_v = s_v;
                for (int b = 0; b < 16; b++) run_m[b] <= 0;
            end else if (BYPASS != byp_prev) begin
                for (int b = 0; b < 16; b++) run_m[b] <= 0;
            end else if (tk) begin
                for (int b = 0; b < 16; b++) begin
                    if (s_v[b] == out_m[b]) begin
                        run_m[b] <= 0;
                    end else if (run_m[b] + 1 == DB) begin
                        o_v[b] = s_v[b];
                        c_v[b] = 1'b1;
                        run_m[b] <= 0;
                    end else begin
                        run_m[b] <= run_m[b] + 1;
                    end
                end
            end
            out_m    <= o_v;
            chg_m    <= c_v;
            rel_m    <= rel_m + 1;
            byp_prev <= BYPASS;
        end
        t_abs <= t_abs + 1;
    end

    always @(negedge CLK) begin
        if (mon_en) begin
            check("model", {PA, PB, PA_CHG, PB_CHG},
                  {out_m[7:0], out_m[15:8], chg_m[7:0], chg_m[15:8]});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_port(input bit sel_b, input logic [7:0] target, input int start,
                             input int maxc, output int n);
        n = start;
        while (((sel_b ? PB : PA) !== target) && n < maxc) begin
            @(negedge CLK);
            n++;
        end
    endtask

    typedef struct {
        logic [7:0] pa_raw;
        logic [7:0] pb_raw;
        logic       bypass;
        int         hold;
        logic [7:0] exp_pa;
        logic [7:0] exp_pb;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int n;
        int n_fall;
        int n_strb;
        int fall_at;
        logic prev_pb0;

        tbl[0] = '{8'h5A, 8'hC3, 1'b0, 16, 8'h5A, 8'hC3};
        tbl[1] = '{8'hA5, 8'h3C, 1'b1, 4,  8'hA5, 8'h3C};
        tbl[2] = '{8'h00, 8'hFF, 1'b1, 4,  8'h00, 8'hFF};
        tbl[3] = '{8'hFF, 8'h00, 1'b0, 16, 8'hFF, 8'h00};
        tbl[4] = '{8'h0F, 8'hF0, 1'b0, 16, 8'h0F, 8'hF0};
        tbl[5] = '{8'hEF, 8'hF7, 1'b1, 4,  8'hEF, 8'hF7};
        tbl[6] = '{8'hFF, 8'hFF, 1'b0, 16, 8'hFF, 8'hFF};

        // Reset with joystick lines held low
        RES = 1'b1; BYPASS = 1'b0; PA_RAW = 8'h00; PB_RAW = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            mon_en = 1'b1;
            check("rst_ports", {PA, PB}, 16'hFFFF);
            check("rst_chg", {PA_CHG, PB_CHG}, 16'h0000);
        end
        RES = 1'b0;
        @(negedge CLK);
        check("rel_first", {PA, PA_CHG, PB_CHG}, 24'hFF0000);
        wait_port(1'b0, 8'h00, 1, 20, n);
        check_range("rel_latency", n, 11, 14);
        check("rel_strobe", {PA_CHG, PB_CHG}, 16'hFF00);
        @(negedge CLK);
        check("rel_strobe_end", {PA_CHG, PB_CHG}, 16'h0000);
        PA_RAW = 8'hFF;
        cyc(20);

        // Press P0 up
        PA_RAW = 8'hEF;
        wait_port(1'b0, 8'hEF, 0, 20, n);
        check_range("press_latency", n, 11, 14);
        check("press_strobe", {PA_CHG, PB_CHG}, 16'h1000);
        @(negedge CLK);
        check("press_strobe_end", {PA, PA_CHG}, 16'hEF00);
        PA_RAW = 8'hFF;
        cyc(20);

        // Short glitch must never reach PA
        PA_RAW = 8'hFE;
        for (int i = 0; i < 25; i++) begin
            if (i == 5) PA_RAW = 8'hFF;
            @(negedge CLK);
            check("glitch", {PA, PA_CHG}, 16'hFF00);
        end

        // Bounce on PB[0], aligned to the sample phase
        while (rel_m % TD != 0) @(negedge CLK);
        n_fall = 0; n_strb = 0; fall_at = -1; prev_pb0 = PB[0];
        for (int j = 0; j < 44; j++) begin
            if (j < 24 && j % 3 == 0) PB_RAW[0] = ~PB_RAW[0];
            if (j == 24) PB_RAW[0] = 1'b0;
            @(negedge CLK);
            if (prev_pb0 && !PB[0]) begin
                n_fall++;
                fall_at = j - 23;
            end
            if (PB_CHG[0]) n_strb++;
            prev_pb0 = PB[0];
        end
        check("bounce_falls", n_fall, 1);
        check("bounce_strobes", n_strb, 1);
        check_range("bounce_latency", fall_at, 11, 14);
        PB_RAW = 8'hFF;
        cyc(20);

        // Bypass: sync-only path, then return to debounce mid-stream
        BYPASS = 1'b1;
        cyc(3);
        PB_RAW = 8'hFC;
        cyc(1); check("byp_e1", PB, 8'hFF);
        cyc(1); check("byp_e2", PB, 8'hFF);
        cyc(1); check("byp_e3", {PB, PB_CHG}, 16'hFC03);
        cyc(1); check("byp_e4", {PB, PB_CHG}, 16'hFC00);
        BYPASS = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check("byp_exit", {PA, PB, PA_CHG, PB_CHG}, 32'hFFFC0000);
        end
        PB_RAW = 8'hFF;
        cyc(20);

        // Simultaneous P0 right and difficulty 0
        PA_RAW = 8'h7F; PB_RAW = 8'hBF;
        wait_port(1'b0, 8'h7F, 0, 20, n);
        check_range("simul_latency", n, 11, 14);
        check("simul_same_cycle", {PB, PA_CHG, PB_CHG}, 24'hBF8040);
        PA_RAW = 8'hFF; PB_RAW = 8'hFF;
        cyc(20);

        // Same step, reset after two ticks, then a full fresh window
        PA_RAW = 8'h7F; PB_RAW = 8'hBF;
        cyc(8);
        check("midrst_pending", {PA, PB}, 16'hFFFF);
        RES = 1'b1;
        @(negedge CLK);
        check("midrst_ports", {PA, PB, PA_CHG, PB_CHG}, 32'hFFFF0000);
        RES = 1'b0;
        wait_port(1'b0, 8'h7F, 0, 20, n);
        check_range("midrst_latency", n, 11, 14);
        check("midrst_pb", PB, 8'hBF);
        PA_RAW = 8'hFF; PB_RAW = 8'hFF;
        cyc(20);

        // Vector table
        for (int i = 0; i < 7; i++) begin
            PA_RAW = tbl[i].pa_raw;
            PB_RAW = tbl[i].pb_raw;
            BYPASS = tbl[i].bypass;
            cyc(tbl[i].hold);
            check($sformatf("tbl%0d", i), {PA, PB}, {tbl[i].exp_pa, tbl[i].exp_pb});
        end

        // Randomized activity, checked cycle by cycle against the model
        for (int i = 0; i < 250; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                RES = 1'b1;
                cyc(int'($urandom_range(1, 3)));
                RES = 1'b0;
            end else if (r < 15) begin
                BYPASS = ~BYPASS;
            end
            PA_RAW = PA_RAW ^ (8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)));
            PB_RAW = PB_RAW ^ (8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)));
            cyc(int'($urandom_range(1, 20)));
        end
        BYPASS = 1'b0;
        cyc(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
